seq_det_ctrl: RTL and testbench
===============================

Name: seq_det_ctrl

Overview:
Run-controller for the serial pattern detector. Firmware supplies a pattern, its length, a match target and a timeout, then pulses start. The block arms a shift-register match engine on the serial data bit, counts overlapping matches, and ends the run with a done or timeout pulse. It sits between the config/control logic and the single-bit serial data input.

Parameters:
PAT_W, 8, maximum pattern length in bits (2..16)
CNT_W, 8, width of the match target and match counter
TO_W, 16, width of the timeout, in RUN cycles

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle run request; sampled only in IDLE
stop  in  1  abort; sampled in LOAD and RUN
cfg_pattern  in  PAT_W  pattern; bit 0 is the most recent serial bit
cfg_len  in  $clog2(PAT_W+1)  active pattern length
cfg_target  in  CNT_W  matches required for done
cfg_timeout  in  TO_W  RUN-cycle limit; 0 disables the timeout
data  in  1  serial data bit
busy  out  1  high in LOAD, RUN, DONE and TOUT
match_pulse  out  1  one-cycle pulse per detected match
match_cnt  out  CNT_W  matches counted in the current or last run
done  out  1  one-cycle pulse when the target is reached
timeout  out  1  one-cycle pulse when the timeout expires

Behaviour:
- Reset: asynchronous, active-low; clk and rst_n as named above.
  - state=IDLE; all outputs 0; shift register, fill counter and run counter are 0.
- All outputs are registered.
- States: IDLE, LOAD, RUN, DONE, TOUT. One-hot encoding.
- IDLE:
  - start=1 → LOAD.
  - match_cnt holds its last value.
- LOAD (exactly 1 cycle):
  - Latch all cfg_* inputs; cfg inputs are ignored for the rest of the run.
  - Clamp: len 0 → 1; len > PAT_W → PAT_W; target 0 → 1.
  - Clear the shift register, fill counter, run counter and match_cnt.
  - Go to RUN; stop=1 instead → IDLE.
- RUN, on every rising edge:
  - Shift: sh <= {sh[PAT_W-2:0], data}.
  - fill saturates at PAT_W; run_cnt increments.
  - Match condition: fill+1 >= len, and the low len bits of the new sh equal the low len bits of the pattern.
  - Overlapping matches are counted; there is no reset after a match.
- On a match at edge E:
  - match_pulse=1 in the cycle after E; match_cnt increments.
  - If the new count equals the target → DONE, with done=1 in that same cycle.
- Timeout:
  - If the timeout is nonzero, run_cnt+1 == timeout at edge E, and the target was not reached at E → TOUT, with timeout=1 in the cycle after E.
  - Exactly `timeout` bits are sampled.
- Priority at the same edge, highest first:
  1. rst_n
  2. stop (→ IDLE, no done/timeout; a match_pulse from that edge is suppressed)
  3. target reached (DONE)
  4. timeout (TOUT)
- DONE and TOUT last 1 cycle each, then → IDLE. busy drops on entry to IDLE.
- start is ignored when not in IDLE, and never queued.
- Latency from start to the first sampled bit: start sampled at edge 0, LOAD at edge 1, first data sampled at edge 2.
- Reset mid-run: immediate return to the reset values; no done or timeout is produced.

Decomposition:
- Package seq_det_pkg holds:
  - the state encoding localparams;
  - the default PAT_W, CNT_W and TO_W;
  - the clamp helper function for len and target.
- Sub-module pat_match_eng holds:
  - the shift register and fill counter;
  - the masked compare, with ports clk, rst_n, clr, en, data, pattern, len, hit.
- The controller FSM, counters and output registers live in seq_det_ctrl.

Test Plan:
1. Basic match: pattern 4'b1011, len 4, target 1, timeout 0; data 0,1,0,1,1 → match_pulse and done in the cycle after the 5th bit; match_cnt=1; busy low one cycle later.
2. Overlap: pattern 2'b11, len 2, target 3; data 1,1,1,1 → match_pulse after bits 2, 3 and 4; done after bit 4; match_cnt=3.
3. Timeout: pattern 8'hA5, len 8, target 1, timeout 8; data all 0 → timeout pulse after the 8th RUN bit; done never asserted; match_cnt=0.
4. Tie: pattern 1'b1, len 1, target 1, timeout 3; data 0,0,1 → done=1 and timeout=0 after the 3rd bit.
5. Stop and restart:
   - stop asserted during the 3rd RUN cycle → IDLE next cycle, no done or timeout, busy=0.
   - start pulsed while busy → ignored; state trace unchanged.
6. Reset and clamps:
   - rst_n low mid-RUN → all outputs 0 immediately.
   - A new run with len 0, target 0 and data 1 → match and done after the 1st bit.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared defaults, one-hot state encoding and clamp helper for the serial pattern detector.
package seq_det_pkg;

  localparam int unsigned PAT_W_DEF = 8;
  localparam int unsigned CNT_W_DEF = 8;
  localparam int unsigned TO_W_DEF  = 16;

  localparam logic [4:0] ST_IDLE = 5'b00001;
  localparam logic [4:0] ST_LOAD = 5'b00010;
  localparam logic [4:0] ST_RUN  = 5'b00100;
  localparam logic [4:0] ST_DONE = 5'b01000;
  localparam logic [4:0] ST_TOUT = 5'b10000;

  typedef enum logic [4:0] {
    S_IDLE = ST_IDLE,
    S_LOAD = ST_LOAD,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE,
    S_TOUT = ST_TOUT
  } state_e;

  function automatic int unsigned clamp_range(input int unsigned v,
                                              input int unsigned lo,
                                              input int unsigned hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/pat_match_eng.sv
// Shift-register match engine: samples one serial bit per enabled cycle and flags a
// masked pattern match on the value the register is about to take.
module pat_match_eng
  import seq_det_pkg::*;
#(
  parameter int unsigned PAT_W = PAT_W_DEF,
  parameter int unsigned LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             data,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  output logic             hit
);

  logic [PAT_W-1:0] r_sh;
  logic [LEN_W-1:0] r_fill;
  logic [PAT_W-1:0] w_sh_nxt;
  logic [PAT_W-1:0] w_mask;
  logic             w_filled;

  always_comb begin
    w_sh_nxt = {r_sh[PAT_W-2:0], data};
    w_mask   = '0;
    for (int i = 0; i < int'(PAT_W); i++) begin
      w_mask[i] = (i < int'(len));
    end
    w_filled = ({1'b0, r_fill} + (LEN_W+1)'(1)) >= {1'b0, len};
  end

  // Combinational so the controller can register the pulse at the same edge the bit lands.
  assign hit = en && w_filled && (((w_sh_nxt ^ pattern) & w_mask) == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh   <= '0;
      r_fill <= '0;
    end else if (clr) begin
      r_sh   <= '0;
      r_fill <= '0;
    end else if (en) begin
      r_sh <= w_sh_nxt;
      if (r_fill != LEN_W'(PAT_W)) r_fill <= r_fill + LEN_W'(1);
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Run controller for the serial pattern detector: latches config, arms the match engine,
// counts overlapping matches and ends each run with a done or timeout pulse.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int unsigned PAT_W = PAT_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned TO_W  = TO_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         stop,
  input  logic [PAT_W-1:0]             cfg_pattern,
  input  logic [$clog2(PAT_W+1)-1:0]   cfg_len,
  input  logic [CNT_W-1:0]             cfg_target,
  input  logic [TO_W-1:0]              cfg_timeout,
  input  logic                         data,
  output logic                         busy,
  output logic                         match_pulse,
  output logic [CNT_W-1:0]             match_cnt,
  output logic                         done,
  output logic                         timeout
);

  localparam int unsigned LEN_W = $clog2(PAT_W + 1);

  state_e           r_state;
  logic [PAT_W-1:0] r_pat;
  logic [LEN_W-1:0] r_len;
  logic [CNT_W-1:0] r_target;
  logic [CNT_W-1:0] r_match_cnt;
  logic [TO_W-1:0]  r_to;
  logic [TO_W-1:0]  r_run_cnt;
  logic             r_busy;
  logic             r_match_pulse;
  logic             r_done;
  logic             r_tout;

  logic             w_hit;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [TO_W-1:0]  w_run_nxt;
  logic             w_tgt_hit;
  logic             w_to_hit;

  pat_match_eng #(.PAT_W(PAT_W), .LEN_W(LEN_W)) u_eng (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (r_state == S_LOAD),
    .en      (r_state == S_RUN),
    .data    (data),
    .pattern (r_pat),
    .len     (r_len),
    .hit     (w_hit)
  );

  assign w_cnt_nxt = r_match_cnt + CNT_W'(1);
  assign w_run_nxt = r_run_cnt + TO_W'(1);
  assign w_tgt_hit = w_hit && (w_cnt_nxt == r_target);
  assign w_to_hit  = (r_to != '0) && (w_run_nxt == r_to);

  // Control FSM; stop outranks target, target outranks timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_pat         <= '0;
      r_len         <= '0;
      r_target      <= '0;
      r_to          <= '0;
      r_run_cnt     <= '0;
      r_match_cnt   <= '0;
      r_busy        <= 1'b0;
      r_match_pulse <= 1'b0;
      r_done        <= 1'b0;
      r_tout        <= 1'b0;
    end else begin
      r_match_pulse <= 1'b0;
      r_done        <= 1'b0;
      r_tout        <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_LOAD;
            r_busy  <= 1'b1;
          end
        end
        S_LOAD: begin
          r_pat       <= cfg_pattern;
          r_len       <= LEN_W'(clamp_range(32'(cfg_len), 1, PAT_W));
          r_target    <= CNT_W'(clamp_range(32'(cfg_target), 1, 32'hFFFF_FFFF));
          r_to        <= cfg_timeout;
          r_run_cnt   <= '0;
          r_match_cnt <= '0;
          if (stop) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (stop) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_run_cnt <= w_run_nxt;
            if (w_hit) begin
              r_match_pulse <= 1'b1;
              r_match_cnt   <= w_cnt_nxt;
            end
            if (w_tgt_hit) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else if (w_to_hit) begin
              r_state <= S_TOUT;
              r_tout  <= 1'b1;
            end
          end
        end
        S_DONE, S_TOUT: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign match_pulse = r_match_pulse;
  assign match_cnt   = r_match_cnt;
  assign done        = r_done;
  assign timeout     = r_tout;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl: each step drives inputs after an edge and checks all outputs.
module tb_seq_det_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic [7:0]  cfg_pattern;
  logic [3:0]  cfg_len;
  logic [7:0]  cfg_target;
  logic [15:0] cfg_timeout;
  logic        data;
  logic        busy;
  logic        match_pulse;
  logic [7:0]  match_cnt;
  logic        done;
  logic        timeout;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  seq_det_ctrl #(.PAT_W(8), .CNT_W(8), .TO_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_target  (cfg_target),
    .cfg_timeout (cfg_timeout),
    .data        (data),
    .busy        (busy),
    .match_pulse (match_pulse),
    .match_cnt   (match_cnt),
    .done        (done),
    .timeout     (timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Observed/expected packed as {busy, match_pulse, done, timeout, match_cnt}.
  task automatic chk(input string tag, input logic e_busy, input logic e_mp,
                     input logic e_done, input logic e_to, input logic [7:0] e_cnt);
    logic [11:0] obs;
    logic [11:0] exp;
    obs = {busy, match_pulse, done, timeout, match_cnt};
    exp = {e_busy, e_mp, e_done, e_to, e_cnt};
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %03h expected %03h", tag, obs, exp);
    end
  endtask

  // Start a run and leave the DUT in its first RUN cycle; cfg is then scrambled to prove it was latched.
  task automatic begin_run(input logic [7:0] pat, input logic [3:0] len,
                           input logic [7:0] tgt, input logic [15:0] to);
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_target  = tgt;
    cfg_timeout = to;
    data        = 1'b0;
    start       = 1'b1;
    tick();
    start = 1'b0;
    tick();
    cfg_pattern = ~pat;
    cfg_len     = 4'd3;
    cfg_target  = 8'hFF;
    cfg_timeout = 16'd1;
  endtask

  task automatic bit_in(input logic d);
    data = d;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; data = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_target = '0; cfg_timeout = '0;
    #12;
    chk("reset", 0, 0, 0, 0, 8'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_after_reset", 0, 0, 0, 0, 8'd0);

    // Basic match
    begin_run(8'h0B, 4'd4, 8'd1, 16'd0);
    chk("t1_armed", 1, 0, 0, 0, 8'd0);
    bit_in(0); bit_in(1); bit_in(0); bit_in(1);
    chk("t1_pre", 1, 0, 0, 0, 8'd0);
    bit_in(1);
    chk("t1_match", 1, 1, 1, 0, 8'd1);
    tick();
    chk("t1_idle", 0, 0, 0, 0, 8'd1);

    // Overlapping matches
    begin_run(8'h03, 4'd2, 8'd3, 16'd0);
    chk("t2_clear", 1, 0, 0, 0, 8'd0);
    bit_in(1); chk("t2_b1", 1, 0, 0, 0, 8'd0);
    bit_in(1); chk("t2_b2", 1, 1, 0, 0, 8'd1);
    bit_in(1); chk("t2_b3", 1, 1, 0, 0, 8'd2);
    bit_in(1); chk("t2_b4", 1, 1, 1, 0, 8'd3);
    tick();    chk("t2_idle", 0, 0, 0, 0, 8'd3);

    // Timeout after exactly 8 sampled bits
    begin_run(8'hA5, 4'd8, 8'd1, 16'd8);
    for (int i = 0; i < 7; i++) bit_in(0);
    chk("t3_b7", 1, 0, 0, 0, 8'd0);
    bit_in(0);
    chk("t3_tout", 1, 0, 0, 1, 8'd0);
    tick();
    chk("t3_idle", 0, 0, 0, 0, 8'd0);

    // Target and timeout on the same edge: done wins
    begin_run(8'h01, 4'd1, 8'd1, 16'd3);
    bit_in(0); bit_in(0);
    chk("t4_pre", 1, 0, 0, 0, 8'd0);
    bit_in(1);
    chk("t4_tie", 1, 1, 1, 0, 8'd1);
    tick();

    // Stop in the 3rd RUN cycle
    begin_run(8'h01, 4'd1, 8'd5, 16'd0);
    bit_in(1); chk("t5_b1", 1, 1, 0, 0, 8'd1);
    bit_in(0); chk("t5_b2", 1, 0, 0, 0, 8'd1);
    data = 1'b0; stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t5_stop", 0, 0, 0, 0, 8'd1);
    tick();
    chk("t5_stay_idle", 0, 0, 0, 0, 8'd1);

    // start while busy is ignored and never queued
    begin_run(8'h01, 4'd1, 8'd2, 16'd0);
    data = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5_start_in_run", 1, 0, 0, 0, 8'd0);
    bit_in(1); chk("t5_m1", 1, 1, 0, 0, 8'd1);
    data = 1'b1; start = 1'b1;
    tick();
    chk("t5_done", 1, 1, 1, 0, 8'd2);
    tick();
    start = 1'b0;
    chk("t5_done_exit", 0, 0, 0, 0, 8'd2);
    tick();
    chk("t5_no_queue", 0, 0, 0, 0, 8'd2);

    // Asynchronous reset mid-run
    begin_run(8'h01, 4'd1, 8'd3, 16'd0);
    bit_in(1); bit_in(1);
    chk("t6_pre_reset", 1, 1, 0, 0, 8'd2);
    rst_n = 1'b0;
    #2;
    chk("t6_reset", 0, 0, 0, 0, 8'd0);
    #2;
    rst_n = 1'b1;
    tick();
    chk("t6_after_reset", 0, 0, 0, 0, 8'd0);

    // len 0 and target 0 clamp to 1
    begin_run(8'h01, 4'd0, 8'd0, 16'd0);
    bit_in(1);
    chk("t6_clamp_min", 1, 1, 1, 0, 8'd1);
    tick();

    // len above PAT_W clamps to PAT_W
    begin_run(8'hFF, 4'd15, 8'd1, 16'd0);
    for (int i = 0; i < 7; i++) bit_in(1);
    chk("t6_len_b7", 1, 0, 0, 0, 8'd0);
    bit_in(1);
    chk("t6_len_b8", 1, 1, 1, 0, 8'd1);
    tick();
    chk("t6_final_idle", 0, 0, 0, 0, 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
